// File: rtl/game2048_engine.sv
// 4x4 sliding-tile (2048) game core: owns the board, slides/merges one line
// per cycle, spawns a tile from a free-running LFSR and tracks score/win/lose.
module game2048_engine #(
  parameter int unsigned WIN_EXP   = 11,
  parameter int unsigned INIT_A    = 0,
  parameter int unsigned INIT_B    = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 load_en,
  input  logic [15:0][3:0]     load_data,
  output logic [15:0][3:0]     cell_matrix,
  output logic                 win,
  output logic                 lose,
  output logic [15:0]          score,
  output logic                 busy,
  output logic                 move_done
);

  localparam int unsigned SUM_W = 19;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SPAWN, S_CHECK} state_e;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_e;
  typedef logic [15:0][3:0] board_t;
  typedef logic [3:0][3:0]  line_t;

  function automatic board_t init_board();
    board_t b;
    b = '0;
    b[4'(INIT_A)] = 4'd1;
    b[4'(INIT_B)] = 4'd1;
    return b;
  endfunction

  localparam board_t INIT_BOARD = init_board();

  // Cell index of position j (0 = wall) on line k for a given direction.
  function automatic logic [3:0] line_idx(input dir_e d, input logic [1:0] k, input logic [1:0] j);
    case (d)
      D_UP:    return {j, k};
      D_DOWN:  return {~j, k};
      D_LEFT:  return {k, j};
      default: return {k, ~j};
    endcase
  endfunction

  // Compact toward the wall, then merge equal pairs once each from the wall outward.
  function automatic void slide(input line_t v, output line_t o, output logic [17:0] add);
    logic [4:0][3:0] c;
    logic [2:0]      n;
    logic            skip;
    c = '0;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[2'(i)] != 4'd0) begin
        c[n] = v[2'(i)];
        n    = n + 3'd1;
      end
    end
    o    = '0;
    add  = '0;
    n    = '0;
    skip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (c[3'(i)] != 4'd0) begin
        if (c[3'(i + 1)] == c[3'(i)]) begin
          o[n[1:0]] = (c[3'(i)] == 4'hF) ? 4'hF : c[3'(i)] + 4'd1;
          add       = add + (18'd1 << ({1'b0, c[3'(i)]} + 5'd1));
          skip      = 1'b1;
        end else begin
          o[n[1:0]] = c[3'(i)];
        end
        n = n + 3'd1;
      end
    end
  endfunction

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  board_t            cells_q, cells_d;
  logic [1:0]        k_q, k_d;
  logic              changed_q, changed_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [15:0]       score_q, score_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              win_q, win_d, lose_q, lose_d;
  logic              busy_q, move_done_q, move_done_d;

  line_t             old_line, new_line;
  logic [17:0]       line_add;
  logic [SUM_W-1:0]  score_sum;
  logic              any_win, any_zero, any_pair;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    cells_d     = cells_q;
    k_d         = k_q;
    changed_d   = changed_q;
    ptr_d       = ptr_q;
    score_d     = score_q;
    win_d       = win_q;
    lose_d      = lose_q;
    move_done_d = 1'b0;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    for (int j = 0; j < 4; j++) old_line[2'(j)] = cells_q[line_idx(dir_q, k_q, 2'(j))];
    slide(old_line, new_line, line_add);
    score_sum = SUM_W'(score_q) + SUM_W'(line_add);

    // End-of-game scan over the current board.
    any_win  = 1'b0;
    any_zero = 1'b0;
    any_pair = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (cells_q[4'(i)] >= 4'(WIN_EXP)) any_win = 1'b1;
      if (cells_q[4'(i)] == 4'd0) any_zero = 1'b1;
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (cells_q[4'(r * 4 + c)] == cells_q[4'(r * 4 + c + 1)]) any_pair = 1'b1;
        if (cells_q[4'(c * 4 + r)] == cells_q[4'(c * 4 + r + 4)]) any_pair = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (!win_q && !lose_q) begin
          if (load_en) begin
            cells_d = load_data;
            state_d = S_CHECK;
          end else if (btn_up || btn_down || btn_left || btn_right) begin
            if (btn_up)        dir_d = D_UP;
            else if (btn_down) dir_d = D_DOWN;
            else if (btn_left) dir_d = D_LEFT;
            else               dir_d = D_RIGHT;
            changed_d = 1'b0;
            k_d       = 2'd0;
            state_d   = S_MOVE;
          end
        end
      end
      S_MOVE: begin
        for (int j = 0; j < 4; j++) cells_d[line_idx(dir_q, k_q, 2'(j))] = new_line[2'(j)];
        score_d   = (score_sum > SUM_W'(16'hFFFF)) ? 16'hFFFF : score_sum[15:0];
        changed_d = changed_q | (new_line != old_line);
        k_d       = k_q + 2'd1;
        if (k_q == 2'd3) begin
          if (changed_d) begin
            ptr_d   = lfsr_q[3:0];
            state_d = S_SPAWN;
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_SPAWN: begin
        if (cells_q[ptr_q] == 4'd0) begin
          cells_d[ptr_q] = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
          state_d        = S_CHECK;
        end else begin
          ptr_d = ptr_q + 4'd1;
        end
      end
      default: begin
        win_d       = win_q | any_win;
        lose_d      = lose_q | (!any_zero && !any_pair);
        move_done_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dir_q       <= D_UP;
      cells_q     <= INIT_BOARD;
      k_q         <= 2'd0;
      changed_q   <= 1'b0;
      ptr_q       <= 4'd0;
      score_q     <= 16'd0;
      lfsr_q      <= LFSR_SEED;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      busy_q      <= 1'b0;
      move_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cells_q     <= cells_d;
      k_q         <= k_d;
      changed_q   <= changed_d;
      ptr_q       <= ptr_d;
      score_q     <= score_d;
      lfsr_q      <= lfsr_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      busy_q      <= (state_d != S_IDLE);
      move_done_q <= move_done_d;
    end
  end

  assign cell_matrix = cells_q;
  assign win         = win_q;
  assign lose        = lose_q;
  assign score       = score_q;
  assign busy        = busy_q;
  assign move_done   = move_done_q;

endmodule

// File: tb/tb_game2048_engine.sv
// Bench for game2048_engine: directed vector table, hand-written corner
// sequences and randomized boards checked against a queue-based slide model.
module tb_game2048_engine;

  typedef logic [15:0][3:0] board_t;
  typedef struct {
    board_t board;
    int     dir;
    board_t slid;
    int     add;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst, btn_up, btn_down, btn_left, btn_right, load_en;
  board_t           load_data;
  board_t           cell_matrix;
  logic             win, lose, busy, move_done;
  logic [15:0]      score;

  int errors = 0;
  int checks = 0;
  int score_m = 0;

  always #5 clk = ~clk;

  game2048_engine dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .load_en(load_en), .load_data(load_data),
    .cell_matrix(cell_matrix), .win(win), .lose(lose), .score(score),
    .busy(busy), .move_done(move_done)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference slide: gather each line from the wall outward, merge with a queue.
  function automatic void m_slide(input board_t b, input int dir, output board_t o, output int add);
    int idx[4];
    int q[$];
    int r[$];
    int v;
    o = '0;
    add = 0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        case (dir)
          0: idx[j] = j * 4 + k;
          1: idx[j] = (3 - j) * 4 + k;
          2: idx[j] = k * 4 + j;
          default: idx[j] = k * 4 + (3 - j);
        endcase
      end
      q.delete();
      r.delete();
      for (int j = 0; j < 4; j++) if (b[idx[j]] != 0) q.push_back(int'(b[idx[j]]));
      while (q.size() > 0) begin
        v = q.pop_front();
        if (q.size() > 0 && q[0] == v) begin
          void'(q.pop_front());
          r.push_back((v == 15) ? 15 : v + 1);
          add += (1 << (v + 1));
        end else begin
          r.push_back(v);
        end
      end
      for (int j = 0; j < 4; j++) o[idx[j]] = (j < r.size()) ? 4'(r[j]) : 4'd0;
    end
  endfunction

  function automatic bit m_lose(input board_t b);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (b[r * 4 + c] == 0) return 1'b0;
        if (c < 3 && b[r * 4 + c] == b[r * 4 + c + 1]) return 1'b0;
        if (r < 3 && b[r * 4 + c] == b[r * 4 + c + 4]) return 1'b0;
      end
    return 1'b1;
  endfunction

  task automatic wait_done(inout int lat, output bit done);
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(posedge clk); #1;
      lat++;
      if (move_done) done = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    score_m = 0;
  endtask

  task automatic do_load(input board_t b, output int lat, output bit done);
    load_en = 1'b1;
    load_data = b;
    @(posedge clk); #1;
    load_en = 1'b0;
    lat = 0;
    wait_done(lat, done);
  endtask

  task automatic press(input int d, output int lat, output bit done);
    btn_up = (d == 0); btn_down = (d == 1); btn_left = (d == 2); btn_right = (d == 3);
    @(posedge clk); #1;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    lat = 0;
    wait_done(lat, done);
  endtask

  // Compare the board against the slid image; a changing move must add exactly one 1/2 tile in an empty cell.
  task automatic check_after(input string nm, input board_t slid, input bit chg, input int lat, input bit done);
    int diffs;
    bit ok;
    check({nm, "_done"}, 64'(done), 64'd1);
    check({nm, "_busy"}, 64'(busy), 64'd0);
    if (!chg) begin
      check({nm, "_board"}, cell_matrix, slid);
      check({nm, "_lat"}, 64'(lat), 64'd5);
    end else begin
      diffs = 0;
      ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (cell_matrix[i] !== slid[i]) begin
          diffs++;
          if (slid[i] != 0 || !(cell_matrix[i] == 4'd1 || cell_matrix[i] == 4'd2)) ok = 1'b0;
        end
      end
      check({nm, "_spawn_cnt"}, 64'(diffs), 64'd1);
      check({nm, "_spawn_ok"}, 64'(ok), 64'd1);
      check({nm, "_lat_range"}, 64'(lat >= 6 && lat <= 21), 64'd1);
    end
  endtask

  initial begin
    vec_t   vecs[8];
    board_t b, s, snap;
    int     lat, add, d, pulses;
    bit     done, stable;

    vecs[0] = '{64'h0000_0000_0000_1111, 2, 64'h0000_0000_0000_0022, 8};
    vecs[1] = '{64'h0000_0000_0000_0222, 3, 64'h0000_0000_0000_3200, 8};
    vecs[2] = '{64'h0000_0000_0000_0001, 2, 64'h0000_0000_0000_0001, 0};
    vecs[3] = '{64'h0000_0001_0000_0001, 0, 64'h0000_0000_0000_0002, 4};
    vecs[4] = '{64'h0020_0000_0030_0030, 1, 64'h0020_0040_0000_0000, 16};
    vecs[5] = '{64'h0000_1010_0000_0000, 2, 64'h0000_0002_0000_0000, 4};
    vecs[6] = '{64'h0000_0000_3303_0000, 3, 64'h0000_0000_4300_0000, 16};
    vecs[7] = '{64'h1000_0000_0000_0000, 3, 64'h1000_0000_0000_0000, 0};

    rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    load_en = 1'b0; load_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_board", cell_matrix, 64'h11);
    check("rst_win", 64'(win), 64'd0);
    check("rst_lose", 64'(lose), 64'd0);
    check("rst_score", 64'(score), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(move_done), 64'd0);

    // Basic merge straight from reset.
    press(2, lat, done);
    check_after("basic", 64'h2, 1'b1, lat, done);
    check("basic_score", 64'(score), 64'd4);
    @(posedge clk); #1;
    check("basic_pulse_len", 64'(move_done), 64'd0);

    foreach (vecs[i]) begin
      do_reset();
      do_load(vecs[i].board, lat, done);
      check($sformatf("vec%0d_load", i), 64'(lat), 64'd1);
      press(vecs[i].dir, lat, done);
      check_after($sformatf("vec%0d", i), vecs[i].slid, vecs[i].slid != vecs[i].board, lat, done);
      check($sformatf("vec%0d_score", i), 64'(score), 64'(vecs[i].add));
    end

    // Request during busy is dropped, not queued.
    do_reset();
    do_load(64'h0101, lat, done);
    btn_left = 1'b1;
    @(posedge clk); #1;
    btn_left = 1'b0;
    @(posedge clk); #1;
    check("drop_busy_hi", 64'(busy), 64'd1);
    btn_up = 1'b1;
    @(posedge clk); #1;
    btn_up = 1'b0;
    lat = 2;
    wait_done(lat, done);
    check_after("drop", 64'h2, 1'b1, lat, done);
    snap = cell_matrix;
    pulses = 0;
    stable = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (move_done || busy) pulses++;
      if (cell_matrix !== snap) stable = 1'b0;
    end
    check("drop_no_extra", 64'(pulses), 64'd0);
    check("drop_stable", 64'(stable), 64'd1);

    // Win, then further requests ignored.
    do_reset();
    do_load(64'h00AA, lat, done);
    check("win_pre", 64'(win), 64'd0);
    press(2, lat, done);
    check("win_cell0", 64'(cell_matrix[0]), 64'd11);
    check("win_flag", 64'(win), 64'd1);
    check("win_lose", 64'(lose), 64'd0);
    check("win_score", 64'(score), 64'd2048);
    snap = cell_matrix;
    press(3, lat, done);
    check("win_ignored_done", 64'(done), 64'd0);
    check("win_ignored_board", cell_matrix, snap);

    // Full checkerboard: lose one cycle after load.
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r * 4 + c] = ((r + c) % 2 == 1) ? 4'd2 : 4'd1;
    do_load(b, lat, done);
    check("lose_lat", 64'(lat), 64'd1);
    check("lose_flag", 64'(lose), 64'd1);
    check("lose_win", 64'(win), 64'd0);
    check("lose_board", cell_matrix, b);

    // Reset while spawning.
    do_reset();
    do_load(64'h1000, lat, done);
    btn_left = 1'b1;
    @(posedge clk); #1;
    btn_left = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rec_busy", 64'(busy), 64'd1);
    check("rec_moved", 64'(cell_matrix[0]), 64'd1);
    do_reset();
    check("rec_board", cell_matrix, 64'h11);
    check("rec_busy_lo", 64'(busy), 64'd0);
    check("rec_score", 64'(score), 64'd0);

    // Randomized boards against the reference model; score accumulates across loads.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 16; i++) b[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
      do_load(b, lat, done);
      check($sformatf("rnd%0d_load", it), cell_matrix, b);
      check($sformatf("rnd%0d_lose", it), 64'(lose), 64'(m_lose(b)));
      if (m_lose(b)) begin
        do_reset();
        continue;
      end
      d = int'($urandom_range(0, 3));
      m_slide(b, d, s, add);
      score_m = (score_m + add > 65535) ? 65535 : score_m + add;
      press(d, lat, done);
      check_after($sformatf("rnd%0d", it), s, s != b, lat, done);
      check($sformatf("rnd%0d_score", it), 64'(score), 64'(score_m));
      if (lose) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
